// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the multicycle ARM32 control unit: FSM states,
// ALU operation codes, condition codes, mux encodings and the condition
// evaluator used in DECODE.
package arm_ctrl_pkg;

  // Instruction sequencing states of the multicycle controller
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // ALU operation codes (low three bits of ALUControl)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  // Data-processing opcodes as found in Funct[4:1]
  localparam logic [3:0] DP_AND = 4'b0000;
  localparam logic [3:0] DP_EOR = 4'b0001;
  localparam logic [3:0] DP_SUB = 4'b0010;
  localparam logic [3:0] DP_ADD = 4'b0100;
  localparam logic [3:0] DP_CMP = 4'b1010;
  localparam logic [3:0] DP_ORR = 4'b1100;

  // Instruction classes in Op (Instr[27:26])
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Condition codes (Instr[31:28])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Moore control word produced by the FSM for each state. reg_write marks
  // the two writeback states; the top level qualifies it with NoWrite and
  // derives the Rd==R15 PC write from it.
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       alu_funct;
  } ctrl_t;

  // Evaluate an ARM condition code against NZCV; 4'b1111 behaves as AL
  function automatic logic cond_check(input logic [3:0] cond,
                                      input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_check = z;
      COND_NE: cond_check = ~z;
      COND_CS: cond_check = c;
      COND_CC: cond_check = ~c;
      COND_MI: cond_check = n;
      COND_PL: cond_check = ~n;
      COND_VS: cond_check = v;
      COND_VC: cond_check = ~v;
      COND_HI: cond_check = c & ~z;
      COND_LS: cond_check = ~c | z;
      COND_GE: cond_check = (n == v);
      COND_LT: cond_check = (n != v);
      COND_GT: cond_check = ~z & (n == v);
      COND_LE: cond_check = z | (n != v);
      default: cond_check = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mc_fsm.sv
// Moore sequencer for the multicycle datapath: state register, next-state
// selection from the decoded instruction, and per-state control word.
module mc_fsm
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cond_ok,
  input  logic [1:0] op,
  input  logic       funct_i,
  input  logic       funct_l,
  input  logic       undef,
  output state_t     state,
  output ctrl_t      ctrl
);

  state_t state_q, state_d;

  // State register; reset returns the sequencer to FETCH
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state selection; DECODE branches on condition, class and legality
  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!cond_ok || undef) begin
          state_d = S_FETCH;
        end else begin
          case (op)
            OP_DP:   state_d = funct_i ? S_EXECUTEI : S_EXECUTER;
            OP_MEM:  state_d = S_MEMADR;
            OP_BR:   state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   state_d = funct_l ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode: control word depends on the current state only
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
      end
      S_DECODE: begin
        // PC+4 again so R15 reads as PC+8 during register fetch
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
      end
      S_MEMADR: begin
        ctrl.alu_src_b  = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.mem_write  = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_b  = SRCB_RD2;
        ctrl.alu_funct  = 1'b1;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_funct  = 1'b1;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.pc_write   = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/multicycle_control_unit.sv
// Control unit for the multicycle ARM32 datapath. Decodes the instruction
// register, holds NZCV, and combines the sequencer's Moore control word with
// instruction fields to drive the datapath enables and mux selects.
module multicycle_control_unit
  import arm_ctrl_pkg::*;
#(
  parameter int         ALUCTRL_W = 3,
  parameter logic [3:0] FLAG_RST  = 4'b0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 RegWrite,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           Flags,
  output logic                 Illegal
);

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       s_bit;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  // Rn and the operand/offset fields are consumed by the datapath only
  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

  // Data-processing decode results
  logic [2:0] dp_alu;
  logic       dp_valid;
  logic       dp_no_write;
  logic       dp_cv_update;

  logic [3:0] flags_q;
  logic       cond_ok;
  logic       undef;
  logic       no_write;
  logic       is_r15;
  logic       flag_we;
  state_t     state;
  ctrl_t      ctrl;

  // Decode Funct[4:1] into an ALU op plus write/flag qualifiers
  always_comb begin
    dp_alu       = ALU_ADD;
    dp_valid     = 1'b1;
    dp_no_write  = 1'b0;
    dp_cv_update = 1'b0;
    case (cmd)
      DP_ADD: begin
        dp_alu       = ALU_ADD;
        dp_cv_update = 1'b1;
      end
      DP_SUB: begin
        dp_alu       = ALU_SUB;
        dp_cv_update = 1'b1;
      end
      DP_AND: dp_alu = ALU_AND;
      DP_ORR: dp_alu = ALU_ORR;
      DP_EOR: dp_alu = ALU_EOR;
      DP_CMP: begin
        // CMP exists only to set flags, so the S=0 form is undefined
        dp_alu       = ALU_SUB;
        dp_no_write  = 1'b1;
        dp_cv_update = 1'b1;
        dp_valid     = s_bit;
      end
      default: dp_valid = 1'b0;
    endcase
  end

  assign cond_ok = cond_check(cond, flags_q);
  assign undef   = (op == 2'b11) || ((op == OP_DP) && !dp_valid);

  // Memory instructions reuse Funct bits, so NoWrite applies to DP only
  assign no_write = dp_no_write && (op == OP_DP);
  assign is_r15   = (rd == 4'd15);

  mc_fsm u_fsm (
    .clk     (clk),
    .reset   (reset),
    .cond_ok (cond_ok),
    .op      (op),
    .funct_i (funct[5]),
    .funct_l (funct[0]),
    .undef   (undef),
    .state   (state),
    .ctrl    (ctrl)
  );

  // Flags are captured only on the execute edge of an S-suffixed DP op
  assign flag_we = ((state == S_EXECUTER) || (state == S_EXECUTEI)) && s_bit;

  // NZCV register: N,Z follow every flag-setting op, C,V only arithmetic ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= FLAG_RST;
    end else if (flag_we) begin
      flags_q[3:2] <= ALUFlags[3:2];
      if (dp_cv_update) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // Enables are forced low while reset is held, even though the FSM sits in
  // FETCH whose control word would otherwise request PC and IR writes.
  assign PCWrite  = reset && (ctrl.pc_write ||
                              (ctrl.reg_write && is_r15 && !no_write));
  assign RegWrite = reset && ctrl.reg_write && !no_write;
  assign MemWrite = reset && ctrl.mem_write;
  assign IRWrite  = reset && ctrl.ir_write;

  assign AdrSrc     = ctrl.adr_src;
  assign ResultSrc  = ctrl.result_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ALUControl = ALUCTRL_W'(ctrl.alu_funct ? dp_alu : ALU_ADD);
  assign ImmSrc     = op;
  assign RegSrc     = {op == OP_MEM, op == OP_BR};
  assign Flags      = flags_q;
  assign Illegal    = (state == S_DECODE) && cond_ok && undef;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Expected per-cycle control
// vectors are queued as each instruction is issued and compared on the
// falling edge of every clock while the queue holds entries.
module tb_multicycle_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, Illegal;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  Flags;

  int checks = 0;
  int errors = 0;

  typedef enum {FE, DE, MA, MR, MWB, MW, EXR, EXI, AWB, BR} st_e;

  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];

  multicycle_control_unit #(.ALUCTRL_W(3), .FLAG_RST(4'b0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .ALUControl (ALUControl),
    .Flags      (Flags),
    .Illegal    (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected control vector per state, straight from the state table:
  // {PCWrite,MemWrite,IRWrite,RegWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,Illegal}
  function automatic logic [13:0] expv(st_e s, logic rd15, logic nowr,
                                       logic [2:0] aop, logic ill);
    logic pcw, memw, irw, regw, adr, srca;
    logic [1:0] srcb, res;
    logic [2:0] alu;
    pcw = 0; memw = 0; irw = 0; regw = 0; adr = 0; srca = 0;
    srcb = 2'b00; res = 2'b00; alu = 3'b000;
    case (s)
      FE:  begin irw = 1; pcw = 1; srca = 1; srcb = 2'b10; res = 2'b10; end
      DE:  begin srca = 1; srcb = 2'b10; res = 2'b10; end
      MA:  begin srcb = 2'b01; end
      MR:  begin adr = 1; end
      MWB: begin res = 2'b01; regw = 1; pcw = rd15; end
      MW:  begin adr = 1; memw = 1; end
      EXR: begin srcb = 2'b00; alu = aop; end
      EXI: begin srcb = 2'b01; alu = aop; end
      AWB: begin res = 2'b00; regw = ~nowr; pcw = rd15 & ~nowr; end
      BR:  begin srcb = 2'b01; res = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, memw, irw, regw, adr, srca, srcb, res, alu, (s == DE) & ill};
  endfunction

  task automatic push(input string tag, input st_e s, input logic rd15 = 1'b0,
                      input logic nowr = 1'b0, input logic [2:0] aop = 3'b000,
                      input logic ill = 1'b0);
    exp_t e;
    e.tag = tag;
    e.v   = expv(s, rd15, nowr, aop, ill);
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: one expected vector per clock, sampled mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, {18'b0, PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc,
                    ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Illegal},
            {18'b0, e.v});
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; Instr = 32'h0; ALUFlags = 4'h0;
    run(2);
    check("rst_pcwrite",  PCWrite,  0);
    check("rst_irwrite",  IRWrite,  0);
    check("rst_memwrite", MemWrite, 0);
    check("rst_regwrite", RegWrite, 0);
    check("rst_flags",    Flags,    4'b0000);
    reset = 1'b1;

    // ADD R2,R0,#5 (S=0): ALUFlags must not reach the register
    Instr = 32'hE2802005; ALUFlags = 4'b1011;
    push("add", FE); push("add", DE); push("add", EXI, 0, 0, 3'b000);
    push("add", AWB); run(4);
    check("add_flags", Flags, 4'b0000);

    // CMPS R2,#5: no register write, NZCV captured
    Instr = 32'hE3520005; ALUFlags = 4'b0100;
    push("cmp", FE); push("cmp", DE); push("cmp", EXI, 0, 1, 3'b001);
    push("cmp", AWB, 0, 1); run(4);
    check("cmp_flags", Flags, 4'b0100);

    // BEQ with Z=1: taken
    Instr = 32'h0A000002; ALUFlags = 4'b1111;
    push("beq_t", FE); push("beq_t", DE); push("beq_t", BR); run(3);
    check("br_regsrc", RegSrc, 2'b01);
    check("br_immsrc", ImmSrc, 2'b10);
    check("br_flags",  Flags,  4'b0100);

    // CMPS clearing Z, then BEQ falls through in two cycles
    Instr = 32'hE3520005; ALUFlags = 4'b0000;
    push("cmp0", FE); push("cmp0", DE); push("cmp0", EXI, 0, 1, 3'b001);
    push("cmp0", AWB, 0, 1); run(4);
    check("cmp0_flags", Flags, 4'b0000);
    Instr = 32'h0A000002;
    push("beq_nt", FE); push("beq_nt", DE); run(2);

    // BNE with Z=0: taken
    Instr = 32'h1A000002;
    push("bne_t", FE); push("bne_t", DE); push("bne_t", BR); run(3);

    // LDR R1,[R0]
    Instr = 32'hE5901000;
    push("ldr", FE); push("ldr", DE); push("ldr", MA); push("ldr", MR);
    push("ldr", MWB); run(5);
    check("ldr_regsrc", RegSrc, 2'b10);
    check("ldr_immsrc", ImmSrc, 2'b01);

    // STR R1,[R0]
    Instr = 32'hE5801000;
    push("str", FE); push("str", DE); push("str", MA); push("str", MW); run(4);

    // EOR R1,R2,R3 (register form, S=0)
    Instr = 32'hE0221003; ALUFlags = 4'b1111;
    push("eor", FE); push("eor", DE); push("eor", EXR, 0, 0, 3'b100);
    push("eor", AWB); run(4);
    check("eor_flags", Flags, 4'b0000);

    // LDR PC,[PC]: writeback also writes PC
    Instr = 32'hE59FF000;
    push("ldrpc", FE); push("ldrpc", DE); push("ldrpc", MA); push("ldrpc", MR);
    push("ldrpc", MWB, 1); run(5);

    // Set C,V via CMPS, then ANDS must update N,Z and keep C,V
    Instr = 32'hE3520005; ALUFlags = 4'b0011;
    push("cmp1", FE); push("cmp1", DE); push("cmp1", EXI, 0, 1, 3'b001);
    push("cmp1", AWB, 0, 1); run(4);
    check("cmp1_flags", Flags, 4'b0011);
    Instr = 32'hE2112001; ALUFlags = 4'b1100;
    push("ands", FE); push("ands", DE); push("ands", EXI, 0, 0, 3'b010);
    push("ands", AWB); run(4);
    check("ands_flags", Flags, 4'b1111);

    // Op=11 and CMP without S are undefined: Illegal pulse, back to FETCH
    Instr = 32'hFC000000;
    push("ill_op", FE); push("ill_op", DE, 0, 0, 3'b000, 1); run(2);
    Instr = 32'hE3420005;
    push("ill_cmp", FE); push("ill_cmp", DE, 0, 0, 3'b000, 1); run(2);

    // Reset asserted during MEMWRITE
    Instr = 32'hE5801000;
    push("str_rst", FE); push("str_rst", DE); push("str_rst", MA); run(3);
    check("mw_memwrite", MemWrite, 1);
    reset = 1'b0;
    #1;
    check("mwrst_memwrite", MemWrite, 0);
    check("mwrst_pcwrite",  PCWrite,  0);
    check("mwrst_flags",    Flags,    4'b0000);
    @(posedge clk); #1;
    reset = 1'b1;

    // First instruction after reset starts from FETCH
    Instr = 32'hE2802005; ALUFlags = 4'b0000;
    push("add2", FE); push("add2", DE); push("add2", EXI, 0, 0, 3'b000);
    push("add2", AWB); run(4);

    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
